arbitro_mux3: RTL and testbench
===============================

Name: arbitro_mux3

Overview:
- Round-robin arbiter sharing one 3:1 datapath mux between three requesters (e.g. register-file write-back or memory-port sources).
- Grants one requester at a time and drives the mux `seletor` with the granted index.
- Signals a valid beat to the downstream consumer and holds a grant for up to MAX_RAJADA accepted beats.
- Sits beside the mux; consumer handshakes via `aceito`.

Parameters:
MAX_RAJADA, 4, max accepted beats per grant before forced rotation; legal range >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  3  request per source; req[i] held high while source i has beats to send
aceito  input  1  downstream accepts the current beat this cycle
seletor  output  2  mux select: 2'b00/01/10 = source 0/1/2; registered
gnt  output  3  one-hot grant, all-zero when idle; registered
valido  output  1  beat valid = |(gnt & req); combinational from registered gnt
ocupado  output  1  high in CONCEDIDO state

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: gnt=3'b000, seletor=2'b00, ocupado=0, valido=0, estado=OCIOSO, contador=0, ultimo=2 (so source 0 has first priority).
- Reset asserted mid-grant: next edge returns all state to reset values. Any pending beat is dropped; `aceito` is ignored during reset.
- seletor never takes 2'b11.
- States: OCIOSO, CONCEDIDO.
- OCIOSO:
  - If req != 0, pick the winner by rotated priority starting at (ultimo+1) mod 3.
  - Next edge: gnt=onehot(winner), seletor=winner, contador=0, go to CONCEDIDO.
  - Latency is 1 cycle from req to gnt. If req == 0, stay idle; seletor holds its last value.
- Beat definition: valido && aceito in a cycle. Each beat increments contador, which is $clog2(MAX_RAJADA+1) bits wide.
- CONCEDIDO release condition, evaluated at the edge (a = granted index):
  - (a) req[a]==0, or
  - (b) a beat occurs with contador==MAX_RAJADA-1.
- On release:
  - ultimo=a.
  - If any req bit is high (for (b) this includes req[a]), re-arbitrate immediately from (a+1) mod 3. The new gnt/seletor appear on the next edge with no idle bubble, and contador=0.
  - Otherwise go to OCIOSO with gnt=0.
- While granted, req changes on other sources have no effect until release.
- A source dropping req while not accepted loses the beat: valido falls the same cycle, and the grant is released at that edge.
- MAX_RAJADA=1: one beat per grant; strict alternation under contention.
- req[a]=1 with aceito=0 indefinitely: grant held; no timeout.

Optional Feature:
- Macro: ARBITRO_PRIORIDADE_FIXA_EN.
- Defined: fixed priority 0 > 1 > 2. ultimo is neither used nor updated, and every arbitration scans from source 0. MAX_RAJADA release still applies, so a lower source may starve.
- Undefined: round-robin as above.

Decomposition:
- Package arbitro_pkg:
  - typedef enum estado_t {OCIOSO, CONCEDIDO}.
  - Constants SEL_FONTE0=2'b00, SEL_FONTE1=2'b01, SEL_FONTE2=2'b10.
  - Function onehot3(idx).
- Sub-module seletor_rr (combinational): inputs req[2:0], inicio[1:0]; outputs idx[1:0], achou. Finds the first set req scanning circularly from inicio. With ARBITRO_PRIORIDADE_FIXA_EN, the parent ties inicio to 0.

Test Plan:
- Reset, then req=3'b000 for 5 cycles -> gnt=000, seletor=00, valido=0, ocupado=0 throughout.
- req=3'b111, aceito=1 constant, MAX_RAJADA=4 -> gnt sequence 001x4 beats, 010x4, 100x4, 001...; no idle cycle between grants; seletor tracks 0,1,2.
- req=3'b010 one cycle pulse into OCIOSO -> gnt=010 next cycle, valido=0 (req low), release at following edge -> back to OCIOSO, ultimo=1; next req=3'b111 grants source 2 first.
- Grant source 0 with aceito=0 for 10 cycles, req=3'b111 -> gnt stays 001, contador stays 0, valido=1 every cycle.
- Assert reset while granted with contador=2 -> next cycle all outputs at reset values; after reset, req=3'b110 grants source 1.
- With ARBITRO_PRIORIDADE_FIXA_EN, MAX_RAJADA=1, req=3'b011, aceito=1 -> gnt alternates 001 only (source 1 never granted while req[0]=1); without the macro -> 001,010,001,010.

Source files
------------

// File: rtl/arbitro_mux3_pkg.sv
// ----------------------------------------------------------------------------
// arbitro_pkg
//   Shared types and helpers for the arbitro_mux3 round-robin arbiter.
//   - estado_t    : arbiter FSM state (OCIOSO = idle, CONCEDIDO = granted)
//   - SEL_FONTE*  : mux select codes for sources 0/1/2 (2'b11 is never used)
//   - onehot3()   : source index -> one-hot grant vector
//   - proximo()   : circular successor of a source index (0->1->2->0)
// ----------------------------------------------------------------------------
package arbitro_pkg;

    typedef enum logic {
        OCIOSO    = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

    localparam logic [1:0] SEL_FONTE0 = 2'b00;
    localparam logic [1:0] SEL_FONTE1 = 2'b01;
    localparam logic [1:0] SEL_FONTE2 = 2'b10;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] r;
        case (idx)
            SEL_FONTE0: r = 3'b001;
            SEL_FONTE1: r = 3'b010;
            SEL_FONTE2: r = 3'b100;
            default:    r = 3'b000;
        endcase
        return r;
    endfunction

    // Wraps at 3 sources; the unused code 2'b11 also maps back to source 0.
    function automatic logic [1:0] proximo(input logic [1:0] idx);
        logic [1:0] r;
        case (idx)
            SEL_FONTE0: r = SEL_FONTE1;
            SEL_FONTE1: r = SEL_FONTE2;
            default:    r = SEL_FONTE0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arbitro_mux3_if.sv
// ----------------------------------------------------------------------------
// arbitro_mux3_if
//   Bundle of the request/grant/beat signals around the shared 3:1 mux.
//
//   Handshake: a beat is transferred in every cycle where valido && aceito.
//   valido = |(gnt & req): the granted source is still requesting. The
//   consumer may hold aceito low indefinitely; the beat then simply waits.
//   If the granted source drops req before acceptance, valido falls in the
//   same cycle and that beat is lost.
//
//   Signals:
//     req[2:0]     requests, one per source (driven by sources)
//     aceito       consumer accepts the current beat (driven by consumer)
//     seletor[1:0] mux select of the granted source (registered)
//     gnt[2:0]     one-hot grant, zero when idle (registered)
//     valido       beat valid (combinational from registered gnt)
//     ocupado      arbiter is in CONCEDIDO
//     estado       FSM state, for observation
//     contador     beats accepted in the current grant, for observation
//
//   Modports: master = arbiter side, slave = sources/consumer side.
// ----------------------------------------------------------------------------
interface arbitro_mux3_if #(
    parameter int MAX_RAJADA = 4
) ();
    import arbitro_pkg::*;

    localparam int CW = $clog2(MAX_RAJADA + 1);

    logic [2:0]    req;
    logic          aceito;
    logic [1:0]    seletor;
    logic [2:0]    gnt;
    logic          valido;
    logic          ocupado;
    estado_t       estado;
    logic [CW-1:0] contador;

    modport master (
        input  req,
        input  aceito,
        output seletor,
        output gnt,
        output valido,
        output ocupado,
        output estado,
        output contador
    );

    modport slave (
        output req,
        output aceito,
        input  seletor,
        input  gnt,
        input  valido,
        input  ocupado,
        input  estado,
        input  contador
    );

endinterface

// File: rtl/arbitro_mux3_seletor_rr.sv
// ----------------------------------------------------------------------------
// seletor_rr
//   Combinational circular priority search over three requests.
//   Scans req starting at index 'inicio' and wrapping (inicio, inicio+1,
//   inicio+2 mod 3) and returns the first set position.
//
//   Ports:
//     req[2:0]    request vector
//     inicio[1:0] first index to examine (2'b11 treated as 0)
//     idx[1:0]    index of the winner (0 when achou = 0)
//     achou       at least one request is set
// ----------------------------------------------------------------------------
module seletor_rr
    import arbitro_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] inicio,
    output logic [1:0] idx,
    output logic       achou
);

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    always_comb begin
        c0 = (inicio == 2'b11) ? SEL_FONTE0 : inicio;
        c1 = proximo(c0);
        c2 = proximo(c1);
    end

    always_comb begin
        idx   = SEL_FONTE0;
        achou = 1'b0;
        if (req[c0]) begin
            idx   = c0;
            achou = 1'b1;
        end else if (req[c1]) begin
            idx   = c1;
            achou = 1'b1;
        end else if (req[c2]) begin
            idx   = c2;
            achou = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_mux3.sv
// ----------------------------------------------------------------------------
// arbitro_mux3
//   Round-robin arbiter for one shared 3:1 datapath mux. One source is
//   granted at a time; seletor steers the mux to it and valido flags a beat
//   for the consumer. A grant lasts until the source drops req or until
//   MAX_RAJADA beats have been accepted, then the next requester (searching
//   from the source after the one just served) is granted on the very next
//   edge, with no idle cycle in between.
//
//   Parameters:
//     MAX_RAJADA  beats per grant before forced rotation (>= 1)
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    arbitro_mux3_if.master (req, aceito in; seletor, gnt, valido,
//            ocupado, estado, contador out)
//
//   Build option:
//     ARBITRO_PRIORIDADE_FIXA_EN  fixed priority 0 > 1 > 2: every search
//     starts at source 0 and the last-served index is not kept. The burst
//     limit still ends a grant, but a lower source may starve.
// ----------------------------------------------------------------------------
module arbitro_mux3
    import arbitro_pkg::*;
#(
    parameter int MAX_RAJADA = 4
) (
    input  logic          clk,
    input  logic          reset,
    arbitro_mux3_if.master bus
);

    localparam int CW = $clog2(MAX_RAJADA + 1);
    localparam logic [CW-1:0] ULTIMO_BEAT = CW'(MAX_RAJADA - 1);
    localparam logic [CW-1:0] UM          = CW'(1);

    estado_t       estado;
    logic [2:0]    gnt;
    logic [1:0]    seletor;
    logic [CW-1:0] contador;
    logic          ocupado;

`ifndef ARBITRO_PRIORIDADE_FIXA_EN
    // Last source served; reset to 2 so that source 0 is searched first.
    logic [1:0]    ultimo;
`endif

    logic [1:0] inicio;
    logic [1:0] vencedor;
    logic       achou;
    logic       valido;
    logic       beat;
    logic       libera;

    // gnt is one-hot of seletor while granted, so !valido in CONCEDIDO is
    // exactly "the granted source has dropped its request".
    always_comb begin
        valido = |(gnt & bus.req);
        beat   = valido & bus.aceito;
        libera = (estado == CONCEDIDO) &&
                 (!valido || (beat && (contador == ULTIMO_BEAT)));
    end

    // Search start: in CONCEDIDO the search only matters on release, where
    // it starts after the source being released.
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
    always_comb inicio = SEL_FONTE0;
`else
    always_comb inicio = (estado == CONCEDIDO) ? proximo(seletor) : proximo(ultimo);
`endif

    seletor_rr u_seletor_rr (
        .req    (bus.req),
        .inicio (inicio),
        .idx    (vencedor),
        .achou  (achou)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= OCIOSO;
            gnt      <= 3'b000;
            seletor  <= SEL_FONTE0;
            contador <= '0;
            ocupado  <= 1'b0;
`ifndef ARBITRO_PRIORIDADE_FIXA_EN
            ultimo   <= SEL_FONTE2;
`endif
        end else begin
            case (estado)
                OCIOSO: begin
                    // seletor keeps its last value while idle.
                    if (achou) begin
                        estado   <= CONCEDIDO;
                        gnt      <= onehot3(vencedor);
                        seletor  <= vencedor;
                        contador <= '0;
                        ocupado  <= 1'b1;
                    end
                end

                CONCEDIDO: begin
                    if (libera) begin
`ifndef ARBITRO_PRIORIDADE_FIXA_EN
                        ultimo   <= seletor;
`endif
                        contador <= '0;
                        if (achou) begin
                            // Back-to-back handover, state stays CONCEDIDO.
                            gnt     <= onehot3(vencedor);
                            seletor <= vencedor;
                        end else begin
                            estado  <= OCIOSO;
                            gnt     <= 3'b000;
                            ocupado <= 1'b0;
                        end
                    end else if (beat) begin
                        contador <= contador + UM;
                    end
                end

                default: begin
                    estado  <= OCIOSO;
                    gnt     <= 3'b000;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt;
    assign bus.seletor  = seletor;
    assign bus.valido   = valido;
    assign bus.ocupado  = ocupado;
    assign bus.estado   = estado;
    assign bus.contador = contador;

endmodule

// File: tb/tb_arbitro_mux3.sv
// ----------------------------------------------------------------------------
// tb_arbitro_mux3
//   Two arbiters driven by the same req/aceito/reset: one with MAX_RAJADA=4
//   and one with MAX_RAJADA=1. Outputs are packed as {gnt, seletor, valido,
//   ocupado} and compared against a transaction-level model of the
//   arbitration rules, a table of hand-derived vectors and a few directed
//   sequences.
// ----------------------------------------------------------------------------
module tb_arbitro_mux3;

`ifdef ARBITRO_PRIORIDADE_FIXA_EN
    localparam bit FIXA = 1'b1;
`else
    localparam bit FIXA = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] req_drv;
    logic       aceito_drv;

    arbitro_mux3_if #(.MAX_RAJADA(4)) bus4 ();
    arbitro_mux3_if #(.MAX_RAJADA(1)) bus1 ();

    assign bus4.req    = req_drv;
    assign bus4.aceito = aceito_drv;
    assign bus1.req    = req_drv;
    assign bus1.aceito = aceito_drv;

    arbitro_mux3 #(.MAX_RAJADA(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    arbitro_mux3 #(.MAX_RAJADA(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    task automatic verifica(input string nome, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b required=%b", nome, got, exp);
        end
    endtask

    function automatic logic [6:0] atual(input int i);
        if (i == 0) return {bus4.gnt, bus4.seletor, bus4.valido, bus4.ocupado};
        else        return {bus1.gnt, bus1.seletor, bus1.valido, bus1.ocupado};
    endfunction

    // ---------------- reference model ----------------
    // m_cur = granted source or -1 when idle; m_cnt = beats in this grant.
    int m_cur[2];
    int m_cnt[2];
    int m_last[2];
    int m_sel[2];
    int m_max[2] = '{4, 1};

    function automatic int escolhe(input logic [2:0] r, input int start);
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (start + k) % 3;
            if (r[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset(input int i);
        m_cur[i]  = -1;
        m_cnt[i]  = 0;
        m_last[i] = 2;
        m_sel[i]  = 0;
    endtask

    function automatic logic [6:0] model_saida(input int i);
        logic [2:0] g;
        logic       v;
        g = (m_cur[i] < 0) ? 3'b000 : 3'(1 << m_cur[i]);
        v = (m_cur[i] >= 0) && req_drv[m_cur[i]];
        return {g, 2'(m_sel[i]), v, (m_cur[i] >= 0)};
    endfunction

    task automatic model_borda(input int i);
        int w;
        bit b;
        if (reset) begin
            model_reset(i);
        end else if (m_cur[i] < 0) begin
            w = escolhe(req_drv, FIXA ? 0 : (m_last[i] + 1) % 3);
            if (w >= 0) begin
                m_cur[i] = w;
                m_sel[i] = w;
                m_cnt[i] = 0;
            end
        end else begin
            b = req_drv[m_cur[i]] && aceito_drv;
            if (!req_drv[m_cur[i]] || (b && m_cnt[i] == m_max[i] - 1)) begin
                if (!FIXA) m_last[i] = m_cur[i];
                w = escolhe(req_drv, FIXA ? 0 : (m_cur[i] + 1) % 3);
                m_cnt[i] = 0;
                if (w >= 0) begin
                    m_cur[i] = w;
                    m_sel[i] = w;
                end else begin
                    m_cur[i] = -1;
                end
            end else if (b) begin
                m_cnt[i]++;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change just after the falling edge; drive() leaves 1 time unit
    // for combinational outputs to settle before any check.
    task automatic drive(input logic rs, input logic [2:0] r, input logic a);
        reset      = rs;
        req_drv    = r;
        aceito_drv = a;
        #1;
    endtask

    task automatic avanca();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model_saida(i));
            verifica(i == 0 ? "modelo_max4" : "modelo_max1", atual(i), exp_q.pop_front());
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_borda(i);
        @(negedge clk);
    endtask

    // ---------------- vector table (MAX_RAJADA=4 instance) ----------------
    typedef struct {
        logic       rs;
        logic [2:0] req;
        logic       ac;
        logic [6:0] exp;   // {gnt, seletor, valido, ocupado}
    } vetor_t;

    vetor_t tab[25];

    initial begin
        reset      = 1'b1;
        req_drv    = 3'b000;
        aceito_drv = 1'b0;

        // Idle after reset, then a one-cycle req pulse on source 1.
        for (int k = 0; k < 5; k++) tab[k] = '{1'b0, 3'b000, 1'b0, 7'b000_00_0_0};
        tab[5]  = '{1'b0, 3'b010, 1'b0, 7'b000_00_0_0};
        tab[6]  = '{1'b0, 3'b000, 1'b1, 7'b010_01_0_1};
        tab[7]  = '{1'b0, 3'b000, 1'b0, 7'b000_01_0_0};
        // Reset, then source 0 held with no acceptance.
        tab[8]  = '{1'b1, 3'b000, 1'b0, 7'b000_01_0_0};
        tab[9]  = '{1'b0, 3'b111, 1'b0, 7'b000_00_0_0};
        for (int k = 10; k < 20; k++) tab[k] = '{1'b0, 3'b111, 1'b0, 7'b001_00_1_1};
        // Two beats, then reset with contador=2, then req=110 after reset.
        tab[20] = '{1'b0, 3'b111, 1'b1, 7'b001_00_1_1};
        tab[21] = '{1'b0, 3'b111, 1'b1, 7'b001_00_1_1};
        tab[22] = '{1'b1, 3'b111, 1'b1, 7'b001_00_1_1};
        tab[23] = '{1'b0, 3'b110, 1'b0, 7'b000_00_0_0};
        tab[24] = '{1'b0, 3'b110, 1'b0, 7'b010_01_1_1};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) model_reset(i);
        @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            drive(tab[k].rs, tab[k].req, tab[k].ac);
            verifica($sformatf("tabela[%0d]", k), atual(0), tab[k].exp);
            if (k == 12)
                verifica("contador_sem_aceite", {5'b0, bus4.contador}, 7'd0);
            avanca();
        end

        // Full contention, always accepting: 4 beats per source, no bubbles.
        drive(1'b1, 3'b000, 1'b0); avanca();
        drive(1'b0, 3'b111, 1'b1);
        verifica("contencao_ocioso", {4'b0, bus4.gnt}, 7'd0);
        avanca();
        for (int k = 0; k < 12; k++) begin
            int s;
            s = FIXA ? 0 : (k / 4) % 3;
            drive(1'b0, 3'b111, 1'b1);
            verifica($sformatf("contencao_gnt[%0d]", k), {4'b0, bus4.gnt}, 7'(1 << s));
            verifica($sformatf("contencao_sel[%0d]", k), {5'b0, bus4.seletor}, 7'(s));
            avanca();
        end

        // MAX_RAJADA=1 instance, req=011: alternation (or source 0 only).
        drive(1'b1, 3'b000, 1'b0); avanca();
        drive(1'b0, 3'b011, 1'b1); avanca();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 3'b011, 1'b1);
            verifica($sformatf("rajada1_gnt[%0d]", k), {4'b0, bus1.gnt},
                     (FIXA || (k % 2 == 0)) ? 7'b001 : 7'b010);
            avanca();
        end

        // Source 1 served last -> next full contention starts at source 2.
        drive(1'b1, 3'b000, 1'b0); avanca();
        drive(1'b0, 3'b010, 1'b0); avanca();
        drive(1'b0, 3'b000, 1'b0);
        verifica("pulso_gnt", {bus4.gnt, bus4.valido, 3'b0}, 7'b010_0_000);
        avanca();
        drive(1'b0, 3'b111, 1'b0);
        verifica("pulso_liberado", atual(0), 7'b000_01_0_0);
        avanca();
        drive(1'b0, 3'b111, 1'b0);
        verifica("ultimo_fonte2", {4'b0, bus4.gnt}, FIXA ? 7'b001 : 7'b100);
        avanca();

        // Random traffic against the model; req changes in short bursts.
        begin
            logic [2:0] r;
            r = 3'b000;
            for (int n = 0; n < 2000; n++) begin
                if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
                drive($urandom_range(0, 99) == 0, r, $urandom_range(0, 3) != 0);
                avanca();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
